// File: rtl/asym_fifo_nx1.sv
// Single-clock asymmetric FIFO: stores wide words and streams each one out as
// RATIO narrow sub-words, least-significant first, on a valid/ready interface.
module asym_fifo_nx1 #(
    parameter int WIDTHB     = 18,
    parameter int RATIO      = 4,
    parameter int DEPTHA     = 512,
    parameter int ADDRWIDTHA = 9,
    localparam int WIDTHA    = WIDTHB * RATIO
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTHA-1:0]     wr_data,
    output logic                  full,
    output logic                  overflow,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WIDTHB-1:0]     rd_data,
    output logic                  rd_last,
    output logic                  empty,
    output logic [ADDRWIDTHA:0]   level
);
    localparam int SUBW = $clog2(RATIO);
    localparam logic [ADDRWIDTHA:0] FULL_LVL = (ADDRWIDTHA+1)'(DEPTHA);
    localparam logic [ADDRWIDTHA:0] PTR_ONE  = (ADDRWIDTHA+1)'(1);
    localparam logic [SUBW-1:0]     SUB_LAST = SUBW'(RATIO-1);
    localparam logic [SUBW-1:0]     SUB_ONE  = SUBW'(1);

    typedef enum logic [1:0] {IDLE, FETCH, SERVE} state_e;

    logic [WIDTHA-1:0]   mem [DEPTHA];
    logic [WIDTHA-1:0]   ram_rd_q;

    state_e              state_q, state_d;
    logic [ADDRWIDTHA:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRWIDTHA:0] rd_ptr_q, rd_ptr_d;
    logic [SUBW-1:0]     sub_q, sub_d;
    logic [WIDTHA-1:0]   hold_q, hold_d;
    logic                overflow_q, overflow_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;
    logic [WIDTHB-1:0]   rd_data_q, rd_data_d;
    logic                push, rd_issue;

    // Occupancy comes straight from the pointer flops, so it moves one edge after a push/fetch.
    assign level    = wr_ptr_q - rd_ptr_q;
    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0) && (state_q == IDLE);
    assign overflow = overflow_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_data  = rd_data_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sub_d      = sub_q;
        hold_d     = hold_q;
        overflow_d = overflow_q;
        rd_issue   = 1'b0;

        push = wr_en && !full;
        if (push)
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (wr_en && full)
            overflow_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (level != '0) begin
                    rd_issue = 1'b1;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                hold_d  = ram_rd_q;
                sub_d   = '0;
                state_d = SERVE;
            end
            SERVE: begin
                if (rd_ready) begin
                    if (sub_q != SUB_LAST) begin
                        sub_d = sub_q + SUB_ONE;
                    end else if (level != '0) begin
                        rd_issue = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_issue)
            rd_ptr_d = rd_ptr_q + PTR_ONE;

        // Outputs are registered from next-state values so they line up with state_q.
        rd_valid_d = (state_d == SERVE);
        rd_last_d  = (state_d == SERVE) && (sub_d == SUB_LAST);
        rd_data_d  = hold_d[sub_d*WIDTHB +: WIDTHB];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sub_q      <= '0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sub_q      <= sub_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr_q[ADDRWIDTHA-1:0]] <= wr_data;
        if (rd_issue && !rst)
            ram_rd_q <= mem[rd_ptr_q[ADDRWIDTHA-1:0]];
    end
endmodule

// File: tb/tb_asym_fifo_nx1.sv
// Directed bench for asym_fifo_nx1 (8b x4, depth 4): a scoreboard queue holds the
// expected narrow stream, a negedge monitor pops it on every handshake.
module tb_asym_fifo_nx1;
    logic        clk = 1'b0;
    logic        rst, wr_en, rd_ready;
    logic [31:0] wr_data;
    logic        full, overflow, rd_valid, rd_last, empty;
    logic [7:0]  rd_data;
    logic [2:0]  level;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];

    // test 4 accounting
    logic t4_on = 1'b0;
    logic t4_started;
    int   t4_hs, t4_bub, t4_lvl_max;

    asym_fifo_nx1 #(.WIDTHB(8), .RATIO(4), .DEPTHA(4), .ADDRWIDTHA(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .overflow(overflow), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last), .empty(empty), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] w);
        for (int k = 0; k < 4; k++)
            exp_q.push_back({(k == 3), w[k*8 +: 8]});
    endtask

    task automatic push(input logic [31:0] w, input logic accepted);
        wr_en   = 1'b1;
        wr_data = w;
        if (accepted) push_exp(w);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_empty(input string nm, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (empty && !rd_valid) break;
            tick();
        end
        chk(nm, (i < bound), 1);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_valid"}, rd_valid, 0);
        chk({nm, "_last"},  rd_last, 0);
        chk({nm, "_data"},  rd_data, 0);
        chk({nm, "_empty"}, empty, 1);
        chk({nm, "_level"}, level, 0);
        chk({nm, "_full"},  full, 0);
        chk({nm, "_ovf"},   overflow, 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL stream_extra: got %0h/%0b expected nothing", rd_data, rd_last);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({rd_last, rd_data} !== e) begin
                    n_err++;
                    $display("FAIL stream: got %0h/%0b expected %0h/%0b",
                             rd_data, rd_last, e[7:0], e[8]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (t4_on) begin
            if (int'(level) > t4_lvl_max) t4_lvl_max = int'(level);
            if (rd_valid) begin
                t4_started = 1'b1;
                if (rd_ready) t4_hs++;
            end else if (t4_started && t4_hs < 400) begin
                t4_bub++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_reset_vals("rst0");

        // 1: single word, latency t+3, LSB first
        rd_ready = 1'b1;
        wr_en = 1'b1; wr_data = 32'h44332211; push_exp(32'h44332211);
        tick(); wr_en = 1'b0;
        chk("t1_lvl1", level, 1);
        chk("t1_v1", rd_valid, 0);
        tick();
        chk("t1_v2", rd_valid, 0);
        tick();
        chk("t1_v3", rd_valid, 1);
        chk("t1_d3", rd_data, 8'h11);
        tick(); tick(); tick(); tick();
        chk("t1_empty", empty, 1);
        chk("t1_vend", rd_valid, 0);

        // 2: fill with consumer stalled, then overflow
        rd_ready = 1'b0;
        push(32'h13121110, 1); push(32'h23222120, 1);
        push(32'h33323130, 1); push(32'h43424140, 1);
        chk("t2_lvl3", level, 3);
        chk("t2_full3", full, 0);
        chk("t2_hold", rd_data, 8'h10);
        push(32'h53525150, 1);
        chk("t2_lvl4", level, 4);
        chk("t2_full4", full, 1);
        chk("t2_ovf_pre", overflow, 0);
        push(32'h63626160, 0);
        chk("t2_ovf", overflow, 1);
        chk("t2_lvl_drop", level, 4);
        rd_ready = 1'b1;
        wait_empty("t2_drain", 100);
        chk("t2_ovf_sticky", overflow, 1);
        do_reset();
        chk("t2_ovf_clr", overflow, 0);

        // 3: stall pattern 1,0,0,1 while draining
        rd_ready = 1'b0;
        push(32'hA3A2A1A0, 1); push(32'hB3B2B1B0, 1);
        push(32'hC3C2C1C0, 1); push(32'hD3D2D1D0, 1);
        for (int i = 0; i < 120; i++) begin
            logic [7:0] d0;
            logic v0, r0;
            if (empty && !rd_valid) break;
            rd_ready = (i % 4 == 0) || (i % 4 == 3);
            d0 = rd_data; v0 = rd_valid; r0 = rd_ready;
            tick();
            if (v0 && !r0) begin
                chk("t3_stall_valid", rd_valid, 1);
                chk("t3_stall_data", rd_data, d0);
            end
        end
        chk("t3_done", exp_q.size(), 0);

        // 4: sustained traffic, one bubble per wide word
        rd_ready = 1'b1;
        t4_started = 1'b0; t4_hs = 0; t4_bub = 0; t4_lvl_max = 0;
        t4_on = 1'b1;
        begin
            int sent;
            sent = 0;
            for (int c = 0; c < 2000 && sent < 100; c++) begin
                if (!full) begin
                    logic [31:0] w;
                    w = $urandom;
                    wr_en = 1'b1; wr_data = w; push_exp(w);
                    sent++;
                end else begin
                    wr_en = 1'b0;
                end
                tick();
            end
            wr_en = 1'b0;
            chk("t4_sent", sent, 100);
        end
        wait_empty("t4_drain", 100);
        t4_on = 1'b0;
        chk("t4_hs", t4_hs, 400);
        chk("t4_bubbles", t4_bub, 99);
        chk("t4_lvl_max", (t4_lvl_max <= 4), 1);
        chk("t4_ovf", overflow, 0);

        // 5: rd_last accepted while full, same-cycle push rejected
        rd_ready = 1'b0;
        push(32'h17161514, 1); push(32'h27262524, 1);
        push(32'h37363534, 1); push(32'h47464544, 1);
        push(32'h57565554, 1);
        chk("t5_full", full, 1);
        rd_ready = 1'b1;
        tick(); tick(); tick();
        chk("t5_last", rd_last, 1);
        chk("t5_full_last", full, 1);
        push(32'hEEEEEEEE, 0);
        chk("t5_ovf", overflow, 1);
        chk("t5_full_after", full, 0);
        chk("t5_lvl3", level, 3);
        push(32'h67666564, 1);
        chk("t5_lvl4", level, 4);
        wait_empty("t5_drain", 100);

        // 6: reset mid-SERVE with level 2
        rd_ready = 1'b0;
        push(32'h0F0E0D0C, 1); push(32'h1F1E1D1C, 1); push(32'h2F2E2D2C, 1);
        chk("t6_valid", rd_valid, 1);
        chk("t6_lvl2", level, 2);
        do_reset();
        chk_reset_vals("t6_rst");
        rd_ready = 1'b1;
        push(32'hDDCCBBAA, 1);
        wait_empty("t6_drain", 50);
        tick(); tick();
        chk("t6_quiet", rd_valid, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
